// File: rtl/wfifo_level.sv
// rtl/wfifo_level.sv - write-domain status tracker for the async FIFO
// Synchronizes the Gray read pointer into wclk, derives occupancy/almost-full, and tracks dropped writes.
module wfifo_level #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   rptr,
  input  logic [ADDR_WIDTH:0]   wptr,
  input  logic                  winc,
  input  logic                  full,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH:0]   rptr_sync,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  rbin_s;
  logic [PW-1:0]                  wbin;
  logic [PW-1:0]                  diff;
  logic                           af_hit;
  logic                           drop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain: each Gray bit is sampled independently, only one bit changes at a time.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rptr};
    end
  end

  assign rptr_sync = sync_q[SYNC_STAGES-1];
  assign rbin_s    = gray2bin(rptr_sync);
  assign wbin      = gray2bin(wptr);
  assign diff      = wbin - rbin_s;
  assign af_hit    = {{(32 - PW){1'b0}}, diff} >= AF_LEVEL;
  assign drop      = winc & full;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wlevel      <= '0;
      almost_full <= 1'b0;
    end else begin
      wlevel      <= diff;
      almost_full <= af_hit;
    end
  end

  // A drop coinciding with a clear wins, so no rejected write goes unrecorded.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      overflow <= drop | (overflow & ~ovf_clr);
      if (ovf_clr) begin
        drop_cnt <= {7'd0, drop};
      end else if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
